// File: rtl/clk_en_xfer_pkg.sv
// Shared types and constants for the clock-enable transfer controller.
// Optional overflow feature is enabled with CLK_EN_XFER_OVF_EN.
package clk_en_xfer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } xfer_state_t;

    localparam int unsigned DEFAULT_RATIO = 1;

    localparam xfer_state_t RST_STATE     = IDLE;
    localparam logic        RST_IN_READY  = 1'b1;
    localparam logic        RST_BUSY      = 1'b0;
    localparam logic        RST_OUT_VALID = 1'b0;
    localparam logic        RST_TICK      = 1'b0;

endpackage

// File: rtl/clk_en_xfer_ctrl_if.sv
// Handshake / datapath bundle between fast-domain producer and the controller.
// Carries ovf/ovf_clr only when CLK_EN_XFER_OVF_EN is defined.
interface clk_en_xfer_ctrl_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 4
);
    logic [CNT_W-1:0] div_ratio;
    logic             div_load;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic             tick;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             busy;
`ifdef CLK_EN_XFER_OVF_EN
    logic             ovf;
    logic             ovf_clr;
`endif

    modport master (
`ifdef CLK_EN_XFER_OVF_EN
        output ovf_clr,
        input  ovf,
`endif
        output div_ratio, div_load, in_valid, in_data,
        input  in_ready, tick, out_valid, out_data, busy
    );

    modport slave (
`ifdef CLK_EN_XFER_OVF_EN
        input  ovf_clr,
        output ovf,
`endif
        input  div_ratio, div_load, in_valid, in_data,
        output in_ready, tick, out_valid, out_data, busy
    );
endinterface

// File: rtl/clk_en_tick_gen.sv
// Programmable divider producing a registered one-cycle clock enable.
// Tick period is ratio+1 clocks; div_load restarts the count with tick held low.
module clk_en_tick_gen
    import clk_en_xfer_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ratio;
    logic             at_top;

    assign at_top = (cnt == ratio);

    // tick is the registered image of the wrap condition, so it appears in the
    // cycle after the counter reaches ratio and a load always yields tick=0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            ratio <= CNT_W'(DEFAULT_RATIO);
            tick  <= RST_TICK;
        end else if (div_load) begin
            cnt   <= '0;
            ratio <= div_ratio;
            tick  <= 1'b0;
        end else begin
            tick <= at_top;
            cnt  <= at_top ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_en_xfer_ctrl.sv
// Single-entry transfer buffer presenting fast-domain data on slow tick cycles.
// Define CLK_EN_XFER_OVF_EN to add the sticky producer-stall flag (ovf/ovf_clr).
module clk_en_xfer_ctrl
    import clk_en_xfer_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 4
) (
    input logic               clock,
    input logic               reset,
    clk_en_xfer_ctrl_if.slave bus
);

    xfer_state_t   state;
    logic [DW-1:0] xfer_buf;
    logic          tick;
    logic          in_ready_q;
    logic          busy_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;

    clk_en_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clock     (clock),
        .reset     (reset),
        .div_ratio (bus.div_ratio),
        .div_load  (bus.div_load),
        .tick      (tick)
    );

    // Accepted data sits in HOLD until a later tick, so a tick coinciding with
    // acceptance never presents that data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RST_STATE;
            xfer_buf    <= '0;
            in_ready_q  <= RST_IN_READY;
            busy_q      <= RST_BUSY;
            out_valid_q <= RST_OUT_VALID;
            out_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        out_valid_q <= 1'b0;
                    end
                    if (bus.in_valid) begin
                        xfer_buf   <= bus.in_data;
                        state      <= HOLD;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        out_data_q  <= xfer_buf;
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tick      = tick;
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

`ifdef CLK_EN_XFER_OVF_EN
    logic stall;
    logic stall_q;
    logic ovf_q;

    assign stall = bus.in_valid & ~in_ready_q;

    // A stalled tick always ends the stall run (HOLD leaves on tick), so a
    // stall spanning a tick is one that was already stalled when the tick came.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            stall_q <= stall;
            if (stall && stall_q && tick) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
